// File: rtl/dec_unbinder_seq_pkg.sv
// Shared HDC configuration for the encoder binders and the decoder unbinder.
// Holds the geometry, the per-feature rotation table and the unbinder FSM state type.
package dec_unbinder_seq_pkg;

  localparam int HV_DIM          = 32;
  localparam int FEATURES_PER_CC = 4;
  localparam int SHIFT_W         = 7;
  localparam int N_SHIFTS        = 8;
  localparam int IDX_W           = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1;

  // Amounts may exceed HV_DIM; every consumer reduces them mod HV_DIM.
  localparam logic [SHIFT_W-1:0] SHIFTS [0:N_SHIFTS-1] = '{
    7'd5, 7'd31, 7'd0, 7'd64, 7'd13, 7'd32, 7'd7, 7'd95
  };

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/unbind_rotr.sv
// Combinational HV_DIM-wide right rotator; amount is reduced mod HV_DIM.
// Zero latency, no flow control.
module unbind_rotr
  import dec_unbinder_seq_pkg::*;
(
  input  logic [HV_DIM-1:0]  in_hv,
  input  logic [SHIFT_W-1:0] amt,
  output logic [HV_DIM-1:0]  out_hv
);

  int amt_mod;

  // A left shift by HV_DIM yields zero, so amt_mod == 0 degenerates cleanly to identity.
  always_comb begin
    amt_mod = int'(amt) % HV_DIM;
    out_hv  = (in_hv >> amt_mod) | (in_hv << (HV_DIM - amt_mod));
  end

endmodule

// File: rtl/dec_unbinder_seq.sv
// Captures a bound pack of FEATURES_PER_CC hypervectors and emits one unbound word per out handshake.
// First word one cycle after the input handshake; stalls hold outputs; no new pack until the last word leaves.
module dec_unbinder_seq
  import dec_unbinder_seq_pkg::*;
#(
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES_PER_CC - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HV_DIM-1:0]  buf_q [0:FEATURES_PER_CC-1];
  logic [HV_DIM-1:0]  buf_d [0:FEATURES_PER_CC-1];
  logic [SHIFT_W-1:0] feat_shift [0:FEATURES_PER_CC-1];
  logic [HV_DIM-1:0]  rot_out;

  always_comb begin
    for (int i = 0; i < FEATURES_PER_CC; i++) begin
      feat_shift[i] = SHIFTS[BASE_IDX + i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          idx_d   = '0;
          buf_d   = shifted_hv;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Pack storage is only observable in EMIT, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  unbind_rotr u_rotr (
    .in_hv  (buf_q[idx_q]),
    .amt    (feat_shift[idx_q]),
    .out_hv (rot_out)
  );

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == EMIT);
    out_hv    = out_valid ? rot_out : '0;
    out_idx   = idx_q;
    out_last  = out_valid && (idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Scoreboarded bench for dec_unbinder_seq: expected words are queued when a pack is driven.
module tb_dec_unbinder_seq;
  import dec_unbinder_seq_pkg::*;

  typedef struct {
    logic [HV_DIM-1:0] hv;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC-1];
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] out_hv;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  dec_unbinder_seq #(.BASE_IDX(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shifted_hv (shifted_hv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hv     (out_hv),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  function automatic logic [HV_DIM-1:0] rotl(input logic [HV_DIM-1:0] v, input int s);
    logic [HV_DIM-1:0] r;
    int sm;
    sm = s % HV_DIM;
    r  = '0;
    for (int j = 0; j < HV_DIM; j++) r[(j + sm) % HV_DIM] = v[j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [HV_DIM-1:0] hv, input int i);
    exp_t x;
    x.hv   = hv;
    x.idx  = IDX_W'(i);
    x.last = (i == FEATURES_PER_CC - 1);
    exp_q.push_back(x);
  endtask

  // Waits (bounded) for in_ready, then presents the pack for exactly one accepting edge.
  task automatic send_pack(input logic [HV_DIM-1:0] p [0:FEATURES_PER_CC-1]);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_wait: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    in_valid   = 1'b1;
    shifted_hv = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < FEATURES_PER_CC; i++) shifted_hv[i] = '0;
    #3;
    n_checks++;
    if ({out_valid, out_last, out_idx, out_hv} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b last=%0b idx=%0d hv=%h, required all 0",
               out_valid, out_last, out_idx, out_hv);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_onehot();
    logic [HV_DIM-1:0] p [0:FEATURES_PER_CC-1];
    for (int i = 0; i < FEATURES_PER_CC; i++) p[i] = '0;
    p[0] = HV_DIM'(1) << 5;
    push_exp(HV_DIM'(1), 0);
    for (int i = 1; i < FEATURES_PER_CC; i++) push_exp('0, i);
    out_ready = 1'b1;
    send_pack(p);
    for (int k = 0; k < FEATURES_PER_CC; k++) begin
      n_checks++;
      if (!out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL onehot_valid: out_valid=%0b queued=%0d at word %0d, required 1", out_valid, exp_q.size(), k);
      end else begin
        e = exp_q.pop_front();
        if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
          n_fail++;
          $display("FAIL onehot_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                   out_hv, out_idx, out_last, e.hv, e.idx, e.last);
        end
      end
      tick();
    end
    exp_q.delete();
  endtask

  task automatic test_round_trip();
    logic [HV_DIM-1:0] lvl [0:FEATURES_PER_CC-1];
    logic [HV_DIM-1:0] p   [0:FEATURES_PER_CC-1];
    out_ready = 1'b1;
    for (int pk = 0; pk < 3; pk++) begin
      for (int i = 0; i < FEATURES_PER_CC; i++) begin
        lvl[i] = HV_DIM'($urandom);
        p[i]   = rotl(lvl[i], int'(SHIFTS[i]));
        push_exp(lvl[i], i);
      end
      send_pack(p);
      for (int k = 0; k < FEATURES_PER_CC; k++) begin
        n_checks++;
        if (!out_valid || exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rt_valid: out_valid=%0b queued=%0d pack %0d word %0d, required 1",
                   out_valid, exp_q.size(), pk, k);
        end else begin
          e = exp_q.pop_front();
          if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
            n_fail++;
            $display("FAIL rt_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                     out_hv, out_idx, out_last, e.hv, e.idx, e.last);
          end
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rt_in_ready_busy: in_ready=%0b at word %0d, required 0", in_ready, k);
        end
        tick();
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rt_return_idle: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [HV_DIM-1:0] p [0:FEATURES_PER_CC-1];
    p[0] = '0;
    p[1] = HV_DIM'(1);
    p[2] = HV_DIM'($urandom);
    p[3] = HV_DIM'($urandom);
    push_exp('0, 0);
    push_exp(HV_DIM'(2), 1);
    push_exp(p[2], 2);
    push_exp(p[3], 3);
    out_ready = 1'b1;
    send_pack(p);
    for (int k = 0; k < FEATURES_PER_CC; k++) begin
      n_checks++;
      if (!out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wrap_valid: out_valid=%0b queued=%0d at word %0d, required 1", out_valid, exp_q.size(), k);
      end else begin
        e = exp_q.pop_front();
        if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
          n_fail++;
          $display("FAIL wrap_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                   out_hv, out_idx, out_last, e.hv, e.idx, e.last);
        end
      end
      tick();
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [HV_DIM-1:0] lvl [0:FEATURES_PER_CC-1];
    logic [HV_DIM-1:0] p   [0:FEATURES_PER_CC-1];
    for (int i = 0; i < FEATURES_PER_CC; i++) begin
      lvl[i] = HV_DIM'($urandom);
      p[i]   = rotl(lvl[i], int'(SHIFTS[i]));
      push_exp(lvl[i], i);
    end
    out_ready = 1'b1;
    send_pack(p);
    for (int k = 0; k < FEATURES_PER_CC; k++) begin
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          n_checks++;
          if (!out_valid || out_hv !== exp_q[0].hv || out_idx !== IDX_W'(2)) begin
            n_fail++;
            $display("FAIL bp_hold: stall %0d valid=%0b hv=%h idx=%0d, required 1 hv=%h idx=2",
                     s, out_valid, out_hv, out_idx, exp_q[0].hv);
          end
          tick();
        end
        out_ready = 1'b1;
      end
      n_checks++;
      if (!out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bp_valid: out_valid=%0b queued=%0d at word %0d, required 1", out_valid, exp_q.size(), k);
      end else begin
        e = exp_q.pop_front();
        if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
          n_fail++;
          $display("FAIL bp_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                   out_hv, out_idx, out_last, e.hv, e.idx, e.last);
        end
      end
      tick();
    end
    exp_q.delete();
  endtask

  task automatic test_ignore_in_valid();
    logic [HV_DIM-1:0] lvl_a [0:FEATURES_PER_CC-1];
    logic [HV_DIM-1:0] lvl_b [0:FEATURES_PER_CC-1];
    logic [HV_DIM-1:0] p_b   [0:FEATURES_PER_CC-1];
    out_ready = 1'b1;
    for (int i = 0; i < FEATURES_PER_CC; i++) begin
      lvl_a[i]      = HV_DIM'($urandom);
      shifted_hv[i] = rotl(lvl_a[i], int'(SHIFTS[i]));
      push_exp(lvl_a[i], i);
      lvl_b[i]      = HV_DIM'($urandom);
      p_b[i]        = rotl(lvl_b[i], int'(SHIFTS[i]));
    end
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < FEATURES_PER_CC; k++) begin
      for (int i = 0; i < FEATURES_PER_CC; i++) shifted_hv[i] = HV_DIM'($urandom);
      n_checks++;
      if (!out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ign_valid: out_valid=%0b queued=%0d at word %0d, required 1", out_valid, exp_q.size(), k);
      end else begin
        e = exp_q.pop_front();
        if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
          n_fail++;
          $display("FAIL ign_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                   out_hv, out_idx, out_last, e.hv, e.idx, e.last);
        end
      end
      tick();
    end
    shifted_hv = p_b;
    for (int i = 0; i < FEATURES_PER_CC; i++) push_exp(lvl_b[i], i);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_gap: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < FEATURES_PER_CC; k++) begin
      n_checks++;
      if (!out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ign2_valid: out_valid=%0b queued=%0d at word %0d, required 1", out_valid, exp_q.size(), k);
      end else begin
        e = exp_q.pop_front();
        if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
          n_fail++;
          $display("FAIL ign2_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                   out_hv, out_idx, out_last, e.hv, e.idx, e.last);
        end
      end
      tick();
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [HV_DIM-1:0] lvl [0:FEATURES_PER_CC-1];
    logic [HV_DIM-1:0] p   [0:FEATURES_PER_CC-1];
    for (int i = 0; i < FEATURES_PER_CC; i++) begin
      lvl[i] = HV_DIM'($urandom);
      p[i]   = rotl(lvl[i], int'(SHIFTS[i]));
    end
    out_ready = 1'b1;
    send_pack(p);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== IDX_W'(1)) begin
      n_fail++;
      $display("FAIL rst_mid_pre: out_valid=%0b idx=%0d, required 1/1", out_valid, out_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_idx, out_hv} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: valid=%0b last=%0b idx=%0d hv=%h, required all 0",
               out_valid, out_last, out_idx, out_hv);
    end
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < FEATURES_PER_CC; i++) begin
      lvl[i] = HV_DIM'($urandom);
      p[i]   = rotl(lvl[i], int'(SHIFTS[i]));
      push_exp(lvl[i], i);
    end
    send_pack(p);
    for (int k = 0; k < FEATURES_PER_CC; k++) begin
      n_checks++;
      if (!out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rst_next_valid: out_valid=%0b queued=%0d at word %0d, required 1", out_valid, exp_q.size(), k);
      end else begin
        e = exp_q.pop_front();
        if ({out_hv, out_idx, out_last} !== {e.hv, e.idx, e.last}) begin
          n_fail++;
          $display("FAIL rst_next_word: hv=%h idx=%0d last=%0b, required hv=%h idx=%0d last=%0b",
                   out_hv, out_idx, out_last, e.hv, e.idx, e.last);
        end
      end
      tick();
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_round_trip();
    test_wrap();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
